// File: rtl/rgb_output_stage.sv
// Pixel output stage: frame-aligned mode/fill latch, colour select, LATENCY-deep output pipeline.
// Modes: passthrough, colour bars, solid fill, border overlay; blanking and out-of-range force black.
module rgb_output_stage #(
    parameter int unsigned CHAN_W   = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [9:0]            row,
    input  logic [9:0]            column,
    input  logic [3*CHAN_W-1:0]   colour_data,
    input  logic [1:0]            mode,
    input  logic [3*CHAN_W-1:0]   fill_colour,
    output logic [CHAN_W-1:0]     r,
    output logic [CHAN_W-1:0]     g,
    output logic [CHAN_W-1:0]     b,
    output logic                  en_out,
    output logic [1:0]            mode_active
);

    localparam int unsigned PIX_W = 3 * CHAN_W;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_BARS   = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_BORDER = 2'b11
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [PIX_W-1:0]  fill_q, fill_d;
    logic              frame_start;
    logic [2:0]        bar_k;
    logic              on_border;
    logic              out_of_range;
    logic [PIX_W-1:0]  pix_d;
    logic [PIX_W:0]    pipe_q [LATENCY];

    assign frame_start = en && (row == 10'd0) && (column == 10'd0);

    // The (0,0) pixel renders with the values being latched on this same edge.
    always_comb begin
        mode_d = mode_q;
        fill_d = fill_q;
        if (frame_start) begin
            mode_d = mode_e'(mode);
            fill_d = fill_colour;
        end
    end

    always_comb begin
        bar_k = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(column) >= i * BAR_W) bar_k = 3'(i);
        end
    end

    assign on_border    = (row == 10'd0) || (32'(row) == V_ACTIVE - 1) ||
                          (column == 10'd0) || (32'(column) == H_ACTIVE - 1);
    assign out_of_range = (32'(row) >= V_ACTIVE) || (32'(column) >= H_ACTIVE);

    // Bar order white..black maps to r=~k[1], g=~k[2], b=~k[0].
    always_comb begin
        pix_d = '0;
        if (en && !out_of_range) begin
            unique case (mode_d)
                MODE_PASS:   pix_d = colour_data;
                MODE_BARS:   pix_d = {{CHAN_W{~bar_k[1]}}, {CHAN_W{~bar_k[2]}}, {CHAN_W{~bar_k[0]}}};
                MODE_FILL:   pix_d = fill_d;
                MODE_BORDER: pix_d = on_border ? '1 : colour_data;
                default:     pix_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= MODE_PASS;
            fill_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            pipe_q[0] <= {en, pix_d};
            for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign en_out      = pipe_q[LATENCY-1][PIX_W];
    assign r           = pipe_q[LATENCY-1][3*CHAN_W-1:2*CHAN_W];
    assign g           = pipe_q[LATENCY-1][2*CHAN_W-1:CHAN_W];
    assign b           = pipe_q[LATENCY-1][CHAN_W-1:0];
    assign mode_active = mode_q;

endmodule

// File: tb/tb_rgb_output_stage.sv
// Bench for rgb_output_stage: default instance plus a CHAN_W=8/LATENCY=3 instance,
// directed steps followed by random pixels checked against a queue-based reference model.
module tb_rgb_output_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic [9:0]  row, column;
    logic [1:0]  mode;
    logic [11:0] cd4, fill4;
    logic [23:0] cd8, fill8;

    logic [3:0]  r4, g4, b4;
    logic        en_out4;
    logic [1:0]  ma4;
    logic [7:0]  r8, g8, b8;
    logic        en_out8;
    logic [1:0]  ma8;

    rgb_output_stage dut (
        .clk(clk), .rst(rst), .en(en), .row(row), .column(column),
        .colour_data(cd4), .mode(mode), .fill_colour(fill4),
        .r(r4), .g(g4), .b(b4), .en_out(en_out4), .mode_active(ma4)
    );

    rgb_output_stage #(.CHAN_W(8), .LATENCY(3)) dut8 (
        .clk(clk), .rst(rst), .en(en), .row(row), .column(column),
        .colour_data(cd8), .mode(mode), .fill_colour(fill8),
        .r(r8), .g(g8), .b(b8), .en_out(en_out8), .mode_active(ma8)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int          m_mode;
    logic [23:0] m_fill4, m_fill8;
    logic [24:0] q4[$];
    logic [24:0] q8[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int cw, input bit e, input int rw, input int cl,
                                              input int md, input logic [23:0] data,
                                              input logic [23:0] fill);
        int full, rr, gg, bb, k, flags;
        full = (1 << cw) - 1;
        if (!e || rw >= 480 || cl >= 640) return 24'h0;
        case (md)
            0: return data;
            1: begin
                k = cl / 80;
                case (k)
                    0: flags = 7;  // white
                    1: flags = 6;  // yellow
                    2: flags = 3;  // cyan
                    3: flags = 2;  // green
                    4: flags = 5;  // magenta
                    5: flags = 4;  // red
                    6: flags = 1;  // blue
                    default: flags = 0;
                endcase
                rr = (flags & 4) ? full : 0;
                gg = (flags & 2) ? full : 0;
                bb = (flags & 1) ? full : 0;
                return 24'((rr << (2 * cw)) | (gg << cw) | bb);
            end
            2: return fill;
            default: begin
                if (rw == 0 || rw == 479 || cl == 0 || cl == 639)
                    return 24'((1 << (3 * cw)) - 1);
                return data;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_mode = 0; m_fill4 = '0; m_fill8 = '0;
            q4.delete(); q8.delete();
            q4.push_back('0);
            repeat (3) q8.push_back('0);
        end else begin
            if (en && row == 0 && column == 0) begin
                m_mode = int'(mode); m_fill4 = {12'h0, fill4}; m_fill8 = fill8;
            end
            q4.push_back({en, model_pix(4, en, int'(row), int'(column), m_mode, {12'h0, cd4}, m_fill4)});
            q8.push_back({en, model_pix(8, en, int'(row), int'(column), m_mode, cd8, m_fill8)});
            while (q4.size() > 1) void'(q4.pop_front());
            while (q8.size() > 3) void'(q8.pop_front());
        end
        #1;
        chk("pix4", {19'h0, en_out4, r4, g4, b4}, {19'h0, q4[0][24], q4[0][11:0]});
        chk("pix8", {7'h0, en_out8, r8, g8, b8}, {7'h0, q8[0]});
        chk("mode4", {30'h0, ma4}, 32'(m_mode));
        chk("mode8", {30'h0, ma8}, 32'(m_mode));
    endtask

    task automatic px(input bit e, input int rw, input int cl);
        en = e; row = 10'(rw); column = 10'(cl);
    endtask

    initial begin
        rst = 1'b0; mode = 2'b00; cd4 = '0; fill4 = '0; cd8 = '0; fill8 = '0;
        px(0, 0, 0);
        m_mode = 0; m_fill4 = '0; m_fill8 = '0;

        // Reset
        @(posedge clk); #1;
        tick();
        chk("rst_rgb", {20'h0, r4, g4, b4}, 32'h0);
        chk("rst_en_out", {31'h0, en_out4}, 32'h0);
        chk("rst_mode", {30'h0, ma4}, 32'h0);

        // Passthrough, and 3-edge latency on the wide instance
        rst = 1'b1; px(1, 200, 300); cd4 = 12'hF00; cd8 = 24'hFF0000;
        tick();
        chk("pass_rgb", {20'h0, r4, g4, b4}, 32'hF00);
        chk("lat3_e1", {24'h0, r8}, 32'h0);
        tick();
        chk("lat3_e2", {24'h0, r8}, 32'h0);
        tick();
        chk("lat3_e3", {8'h0, r8, g8, b8}, 32'hFF0000);

        // Blanking
        cd4 = 12'h0F0; px(0, 200, 300);
        tick();
        chk("blank_rgb", {20'h0, r4, g4, b4}, 32'h0);
        chk("blank_en", {31'h0, en_out4}, 32'h0);

        // Deferred mode switch to colour bars
        mode = 2'b01; px(1, 200, 300);
        tick();
        chk("defer_mode", {30'h0, ma4}, 32'h0);
        chk("defer_pass", {20'h0, r4, g4, b4}, 32'h0F0);
        px(1, 0, 0);
        tick();
        chk("bars_mode", {30'h0, ma4}, 32'h1);
        chk("bars_white", {20'h0, r4, g4, b4}, 32'hFFF);
        px(1, 0, 80);
        tick();
        chk("bars_yellow", {20'h0, r4, g4, b4}, 32'hFF0);
        px(1, 0, 639);
        tick();
        chk("bars_black", {20'h0, r4, g4, b4}, 32'h0);

        // Solid fill held through a mid-frame fill_colour change
        mode = 2'b10; fill4 = 12'h5A3; fill8 = 24'h55AA33; px(1, 0, 0);
        tick();
        chk("fill_first", {20'h0, r4, g4, b4}, 32'h5A3);
        fill4 = 12'h000; fill8 = 24'h0; px(1, 100, 100);
        tick();
        chk("fill_hold", {20'h0, r4, g4, b4}, 32'h5A3);

        // Border overlay and out-of-range
        mode = 2'b11; cd4 = 12'h123; cd8 = 24'h112233; px(1, 0, 0);
        tick();
        chk("border_row0", {20'h0, r4, g4, b4}, 32'hFFF);
        px(1, 240, 320);
        tick();
        chk("border_mid", {20'h0, r4, g4, b4}, 32'h123);
        px(1, 240, 639);
        tick();
        chk("border_col639", {20'h0, r4, g4, b4}, 32'hFFF);
        px(1, 240, 700);
        tick();
        chk("range_col700", {20'h0, r4, g4, b4}, 32'h0);
        px(1, 479, 5);
        tick();
        chk("border_row479", {20'h0, r4, g4, b4}, 32'hFFF);
        px(1, 480, 5);
        tick();
        chk("range_row480", {20'h0, r4, g4, b4}, 32'h0);

        // Mid-frame reset during bars
        mode = 2'b01; px(1, 0, 0);
        tick();
        px(1, 10, 100);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_rgb4", {20'h0, r4, g4, b4}, 32'h0);
        chk("midrst_rgb8", {8'h0, r8, g8, b8}, 32'h0);
        chk("midrst_mode", {30'h0, ma4}, 32'h0);
        rst = 1'b1; cd4 = 12'hABC; px(1, 10, 0);
        tick();
        chk("postrst_pass", {20'h0, r4, g4, b4}, 32'hABC);
        chk("postrst_mode", {30'h0, ma4}, 32'h0);

        // Reset coincident with (0,0) must win over the latch
        rst = 1'b0; mode = 2'b10; px(1, 0, 0);
        tick();
        chk("rst_over_latch", {30'h0, ma4}, 32'h0);
        rst = 1'b1;

        // Random pixels, boundary-biased
        for (int n = 0; n < 2000; n++) begin
            int rw, cl;
            case ($urandom_range(0, 5))
                0: rw = 0;
                1: rw = 479;
                2: rw = int'($urandom_range(480, 1023));
                default: rw = int'($urandom_range(0, 479));
            endcase
            case ($urandom_range(0, 5))
                0: cl = 0;
                1: cl = 639;
                2: cl = int'($urandom_range(640, 1023));
                default: cl = int'($urandom_range(0, 639));
            endcase
            if ($urandom_range(0, 9) == 0) begin rw = 0; cl = 0; end
            px($urandom_range(0, 7) != 0, rw, cl);
            mode  = 2'($urandom);
            cd4   = 12'($urandom);
            fill4 = 12'($urandom);
            cd8   = 24'($urandom);
            fill8 = 24'($urandom);
            rst   = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
